// File: rtl/uc_boot_pkg.sv
// Shared types and constants for the program-memory bootstrap loader.
package uc_boot_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DAT_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_CHK    = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } boot_state_t;

  localparam int unsigned BOOT_LEN_MAX = 4095;
  localparam logic [7:0]  CHK_GOOD     = 8'h00;

endpackage

// File: rtl/prog_mem.sv
// Single-port synchronous program RAM with a registered, gated read port.
// The read register is forced to zero whenever rd_en is low so the fetch
// bus only ever shows memory contents once the core has been released.
module prog_mem #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] rdata_r;

  // Storage array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read, zero when reads are not enabled or in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {WORD_W{1'b0}};
    end else if (rd_en) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= {WORD_W{1'b0}};
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/prog_flash_loader.sv
// Bootstrap loader and fetch port for the core's program memory.
// Receives LEN_HI, LEN_LO, len words (hi byte first) and a checksum byte
// whose addition makes the 8-bit sum of the whole stream zero, then
// releases the core and serves registered instruction fetches.
module prog_flash_loader
  import uc_boot_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] pc_out,
  output logic [WORD_W-1:0] flash_data,
  output logic              bootstrapping,
  output logic              boot_error,
  output logic [ADDR_W-1:0] words_loaded
);

  boot_state_t       state_r, next_s;
  logic [11:0]       len_r;
  logic [7:0]        hi_r;
  logic [7:0]        sum_r;
  logic [ADDR_W-1:0] waddr_r;
  logic              rdy_r, boot_r, err_r;

  logic              accept_s;
  logic              mem_we_s;
  logic [11:0]       len_s;
  logic [7:0]        chk_s;
  logic [ADDR_W-1:0] waddr_inc_s;
  logic [ADDR_W-1:0] mem_addr_s;

  assign accept_s    = rx_valid && rdy_r;
  assign len_s       = {len_r[11:8], rx_data};
  assign chk_s       = sum_r + rx_data;
  assign waddr_inc_s = waddr_r + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Next-state decode and memory write strobe.
  always_comb begin
    next_s   = state_r;
    mem_we_s = 1'b0;
    if (accept_s) begin
      case (state_r)
        S_LEN_HI: begin
          if (rx_data[7:4] != 4'h0) begin
            next_s = S_ERR;
          end else begin
            next_s = S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (len_s == 12'd0) begin
            next_s = S_CHK;
          end else begin
            next_s = S_DAT_HI;
          end
        end
        S_DAT_HI: next_s = S_DAT_LO;
        S_DAT_LO: begin
          mem_we_s = 1'b1;
          if (waddr_inc_s == len_r) begin
            next_s = S_CHK;
          end else begin
            next_s = S_DAT_HI;
          end
        end
        S_CHK: begin
          if (chk_s == CHK_GOOD) begin
            next_s = S_RUN;
          end else begin
            next_s = S_ERR;
          end
        end
        default: next_s = state_r;
      endcase
    end else begin
      next_s = state_r;
    end
  end

  // State register and registered status outputs derived from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_LEN_HI;
      rdy_r   <= 1'b1;
      boot_r  <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      rdy_r   <= (next_s != S_RUN) && (next_s != S_ERR);
      boot_r  <= (next_s != S_RUN);
      err_r   <= (next_s == S_ERR);
    end
  end

  // Load datapath: length, pending high byte, checksum and write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r   <= 12'd0;
      hi_r    <= 8'h00;
      sum_r   <= 8'h00;
      waddr_r <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      sum_r <= chk_s;
      case (state_r)
        S_LEN_HI: len_r[11:8] <= rx_data[3:0];
        S_LEN_LO: len_r[7:0]  <= rx_data;
        S_DAT_HI: hi_r        <= rx_data;
        S_DAT_LO: waddr_r     <= waddr_inc_s;
        default:  hi_r        <= hi_r;
      endcase
    end
  end

  // Single memory port: loader owns it until the core is released.
  assign mem_addr_s = (state_r == S_RUN) ? pc_out : waddr_r;

  prog_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_prog_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_s),
    .rd_en (state_r == S_RUN),
    .addr  (mem_addr_s),
    .wdata ({hi_r, rx_data}),
    .rdata (flash_data)
  );

  assign rx_ready      = rdy_r;
  assign bootstrapping = boot_r;
  assign boot_error    = err_r;
  assign words_loaded  = waddr_r;

endmodule

// File: tb/tb_prog_flash_loader.sv
// Directed bench for prog_flash_loader: load, checksum, error and fetch paths.
module tb_prog_flash_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [11:0] pc_out;
  logic [15:0] flash_data;
  logic        bootstrapping;
  logic        boot_error;
  logic [11:0] words_loaded;

  int n_vec  = 0;
  int n_miss = 0;

  prog_flash_loader #(.ADDR_W(12), .DEPTH(4096), .WORD_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .pc_out        (pc_out),
    .flash_data    (flash_data),
    .bootstrapping (bootstrapping),
    .boot_error    (boot_error),
    .words_loaded  (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [11:0] a, input logic [15:0] exp);
    pc_out = a;
    tick();
    chk(tag, flash_data, exp);
  endtask

  // Good stream minus its checksum byte, sent with optional bubbles.
  task automatic send_good_body(input bit bubbles);
    logic [7:0] body [6] = '{8'h00, 8'h02, 8'h61, 8'h05, 8'h62, 8'h03};
    for (int i = 0; i < 6; i++)
      send(body[i], bubbles ? int'($urandom_range(0, 3)) : 0);
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; pc_out = 12'd0;
    do_reset();
    chk("rst_rx_ready", {15'd0, rx_ready}, 16'h0001);
    chk("rst_flash", flash_data, 16'h0000);
    chk("rst_boot", {15'd0, bootstrapping}, 16'h0001);
    chk("rst_err", {15'd0, boot_error}, 16'h0000);
    chk("rst_words", {4'd0, words_loaded}, 16'h0000);

    // Good load
    send_good_body(1'b0);
    chk("good_boot_before_chk", {15'd0, bootstrapping}, 16'h0001);
    chk("good_flash_during_load", flash_data, 16'h0000);
    send(8'h33, 0);
    chk("good_boot", {15'd0, bootstrapping}, 16'h0000);
    chk("good_words", {4'd0, words_loaded}, 16'h0002);
    chk("good_rx_ready", {15'd0, rx_ready}, 16'h0000);
    chk("good_err", {15'd0, boot_error}, 16'h0000);
    fetch("good_fetch0", 12'd0, 16'h6105);
    fetch("good_fetch1", 12'd1, 16'h6203);
    fetch("good_fetch0b", 12'd0, 16'h6105);

    // Bad checksum
    do_reset();
    chk("rst2_flash", flash_data, 16'h0000);
    send_good_body(1'b0);
    send(8'h34, 0);
    chk("bad_err", {15'd0, boot_error}, 16'h0001);
    chk("bad_boot", {15'd0, bootstrapping}, 16'h0001);
    chk("bad_rx_ready", {15'd0, rx_ready}, 16'h0000);
    fetch("bad_flash", 12'd0, 16'h0000);

    // Empty program
    do_reset();
    send(8'h00, 0); send(8'h00, 0);
    chk("empty_boot_pre", {15'd0, bootstrapping}, 16'h0001);
    send(8'h00, 0);
    chk("empty_boot", {15'd0, bootstrapping}, 16'h0000);
    chk("empty_words", {4'd0, words_loaded}, 16'h0000);
    chk("empty_err", {15'd0, boot_error}, 16'h0000);

    // Oversize length
    do_reset();
    send(8'h10, 0);
    chk("over_err", {15'd0, boot_error}, 16'h0001);
    chk("over_rx_ready", {15'd0, rx_ready}, 16'h0000);
    send(8'h00, 0); send(8'h61, 0); send(8'h05, 0);
    chk("over_err_sticky", {15'd0, boot_error}, 16'h0001);
    chk("over_words", {4'd0, words_loaded}, 16'h0000);
    chk("over_boot", {15'd0, bootstrapping}, 16'h0001);

    // Bubbles between bytes
    do_reset();
    send_good_body(1'b1);
    send(8'h33, int'($urandom_range(0, 3)));
    chk("bub_boot", {15'd0, bootstrapping}, 16'h0000);
    chk("bub_words", {4'd0, words_loaded}, 16'h0002);
    fetch("bub_fetch0", 12'd0, 16'h6105);
    fetch("bub_fetch1", 12'd1, 16'h6203);

    // Mid-load reset, then full good load
    do_reset();
    send(8'h00, 0); send(8'h02, 0); send(8'h61, 0);
    send(8'h05, 0);
    chk("mid_words_pre", {4'd0, words_loaded}, 16'h0001);
    do_reset();
    chk("mid_words_rst", {4'd0, words_loaded}, 16'h0000);
    chk("mid_boot_rst", {15'd0, bootstrapping}, 16'h0001);
    chk("mid_rx_ready_rst", {15'd0, rx_ready}, 16'h0001);
    send_good_body(1'b0);
    send(8'h33, 0);
    chk("mid_boot", {15'd0, bootstrapping}, 16'h0000);
    chk("mid_err", {15'd0, boot_error}, 16'h0000);
    chk("mid_words", {4'd0, words_loaded}, 16'h0002);
    fetch("mid_fetch0", 12'd0, 16'h6105);
    fetch("mid_fetch1", 12'd1, 16'h6203);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
